// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered BCD frame data and PWM brightness.
// Define SEG7_BLANK_LEADING_EN to blank zero digits above the most significant non-zero digit.
module seg7_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4*NDIG-1:0] wr_data,
    input  logic [2:0]        bright,
    output logic [6:0]        led_out,
    output logic [NDIG-1:0]   dig_en,
    output logic              frame_done
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DIG_W  = $clog2(NDIG);
    localparam int unsigned SLOT_LAST_I = SCAN_DIV - 1;
    localparam int unsigned DIG_LAST_I  = NDIG - 1;
    localparam int unsigned EIGHTH_I    = SCAN_DIV / 8;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_LAST_I[SLOT_W-1:0];
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_LAST_I[DIG_W-1:0];
    localparam logic [SLOT_W:0]   EIGHTH    = EIGHTH_I[SLOT_W:0];
    localparam logic [SLOT_W:0]   ONE_EXT   = {{SLOT_W{1'b0}}, 1'b1};
    localparam logic [SLOT_W-1:0] GUARD     = {{(SLOT_W-2){1'b0}}, 2'd2};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SCAN,
        ST_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SLOT_W-1:0] r_slot;
    logic [DIG_W-1:0]  r_digit;
    logic [2:0]        r_bright;
    logic [4*NDIG-1:0] r_pend;
    logic [4*NDIG-1:0] r_active;
    logic              r_pend_full;
    logic [6:0]        r_led;
    logic [NDIG-1:0]   r_dig_en;

    logic              w_scanning;
    logic              w_slot_end;
    logic              w_frame_end;
    logic              w_start;
    logic              w_commit;
    logic              w_wr_accept;
    logic [SLOT_W:0]   w_bright_ext;
    logic [SLOT_W:0]   w_thresh;
    logic              w_blank;
    logic              w_lit;
    logic [3:0]        w_cur_nib;
    logic [3:0]        w_nib [NDIG];
    logic [NDIG-1:0]   w_onehot;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg7_decode = 7'b0000001;
            4'd1:    seg7_decode = 7'b1001111;
            4'd2:    seg7_decode = 7'b0010010;
            4'd3:    seg7_decode = 7'b0000110;
            4'd4:    seg7_decode = 7'b1001100;
            4'd5:    seg7_decode = 7'b0100100;
            4'd6:    seg7_decode = 7'b0100000;
            4'd7:    seg7_decode = 7'b0001111;
            4'd8:    seg7_decode = 7'b0000000;
            4'd9:    seg7_decode = 7'b0000100;
            default: seg7_decode = 7'b1111111;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign w_nib[gi]    = r_active[4*gi +: 4];
            assign w_onehot[gi] = (r_digit == DIG_W'(gi));
        end
    endgenerate

`ifdef SEG7_BLANK_LEADING_EN
    logic [NDIG-1:0] w_nz;
    logic [NDIG-1:0] w_keep;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_blank
            assign w_nz[gi] = |w_nib[gi];
            if (gi == 0) begin : g_lsd
                assign w_keep[gi] = 1'b1;
            end else begin : g_upper
                // A digit is kept if it or any more significant digit is non-zero.
                assign w_keep[gi] = |w_nz[NDIG-1:gi];
            end
        end
    endgenerate
    assign w_blank = ~w_keep[r_digit];
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_scanning  = (r_state != ST_OFF);
        w_slot_end  = (r_slot == SLOT_LAST);
        w_frame_end = w_scanning && w_slot_end && (r_digit == DIG_LAST);
        w_wr_accept = wr_valid && !r_pend_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // SCAN and DRAIN advance identically; DRAIN only records that en has dropped.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (en && r_pend_full) begin
                    w_state_next = ST_SCAN;
                    w_start      = 1'b1;
                end
            end
            ST_SCAN, ST_DRAIN: begin
                if (w_frame_end) begin
                    w_state_next = en ? ST_SCAN : ST_OFF;
                end else begin
                    w_state_next = en ? ST_SCAN : ST_DRAIN;
                end
            end
            default: w_state_next = ST_OFF;
        endcase
        w_commit = w_start || (w_frame_end && r_pend_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot      <= '0;
            r_digit     <= '0;
            r_bright    <= 3'd0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_active    <= {NDIG{4'hF}};
        end else begin
            if (w_commit) begin
                r_active <= r_pend;
            end
            // Accept and commit are exclusive: accept needs pending empty, commit needs it full.
            if (w_wr_accept) begin
                r_pend      <= wr_data;
                r_pend_full <= 1'b1;
            end else if (w_commit) begin
                r_pend_full <= 1'b0;
            end
            if (w_scanning) begin
                if (r_slot == '0) begin
                    r_bright <= bright;
                end
                if (w_slot_end) begin
                    r_slot  <= '0;
                    r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
                end else begin
                    r_slot <= r_slot + 1'b1;
                end
            end else begin
                r_slot  <= '0;
                r_digit <= '0;
            end
        end
    end

    always_comb begin
        w_bright_ext = {{(SLOT_W-2){1'b0}}, r_bright};
        w_thresh     = (w_bright_ext + ONE_EXT) * EIGHTH;
        w_cur_nib    = w_nib[r_digit];
        // Slots 0 and 1 stay dark so the previous digit's segments never ghost onto this one.
        w_lit        = w_scanning && (r_slot >= GUARD) && ({1'b0, r_slot} < w_thresh) && !w_blank;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led    <= 7'b1111111;
            r_dig_en <= '0;
        end else begin
            r_dig_en <= w_lit ? w_onehot : '0;
            r_led    <= w_lit ? seg7_decode(w_cur_nib) : 7'b1111111;
        end
    end

    assign wr_ready   = ~r_pend_full;
    assign frame_done = w_frame_end;
    assign led_out    = r_led;
    assign dig_en     = r_dig_en;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with NDIG=4, SCAN_DIV=16 (64-cycle frames).
module tb_seg7_scan_ctrl;

    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 16;

`ifdef SEG7_BLANK_LEADING_EN
    localparam logic [3:0] BLANK_A5 = 4'b1100;
`else
    localparam logic [3:0] BLANK_A5 = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [2:0]  bright;
    logic [6:0]  led_out;
    logic [3:0]  dig_en;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .bright     (bright),
        .led_out    (led_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // Expected digit lighting for scan cycle c (c = 16*digit + slot within a 64-cycle frame).
    function automatic logic lit(input int c, input int b, input logic [3:0] bm);
        int s;
        int d;
        s = c % 16;
        d = (c / 16) % 4;
        lit = (s >= 2) && (s < (b + 1) * 2) && !bm[d];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; bright = 3'd7;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Write a frame and enable; returns on the negedge where scan cycle 0 is current.
    task automatic start_scan(input logic [15:0] v, input logic [2:0] b);
        wr_valid = 1'b1; wr_data = v; en = 1'b1; bright = b;
        $display("write 0x%h bright %0d (start)", v, b);
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; bright = 3'd7;
        repeat (2) @(negedge clk);
        checks++; if (led_out !== 7'b1111111) begin errors++; $display("FAIL reset_led got %b want 1111111", led_out); end
        checks++; if (dig_en !== 4'b0000) begin errors++; $display("FAIL reset_dig_en got %b want 0000", dig_en); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        reset = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (dig_en !== 4'b0000 || frame_done !== 1'b0) begin
                errors++; $display("FAIL off_no_data dig_en %b frame_done %b want 0000/0", dig_en, frame_done);
            end
        end
    endtask

    task automatic test_scan();
        logic [15:0] vals [4];
        int          brs  [4];
        logic [3:0]  bms  [4];
        int c, d;
        logic l;
        logic [3:0] e_de;
        logic [6:0] e_led;
        vals = '{16'h4321, 16'h4321, 16'h4321, 16'h00A5};
        brs  = '{7, 0, 3, 7};
        bms  = '{4'b0000, 4'b0000, 4'b0000, BLANK_A5};
        for (int t = 0; t < 4; t++) begin
            do_reset();
            start_scan(vals[t], 3'(brs[t]));
            for (int i = 0; i <= 128; i++) begin
                checks++; if (frame_done !== (i % 64 == 63)) begin
                    errors++; $display("FAIL scan%0d_frame_done i=%0d got %b want %b", t, i, frame_done, (i % 64 == 63));
                end
                if (i >= 1) begin
                    c = i - 1;
                    d = (c / 16) % 4;
                    l = lit(c, brs[t], bms[t]);
                    e_de  = l ? (4'b0001 << d) : 4'b0000;
                    e_led = l ? seg(vals[t][4*d +: 4]) : 7'b1111111;
                    checks++; if (dig_en !== e_de) begin
                        errors++; $display("FAIL scan%0d_dig_en c=%0d got %b want %b", t, c, dig_en, e_de);
                    end
                    checks++; if (led_out !== e_led) begin
                        errors++; $display("FAIL scan%0d_led c=%0d got %b want %b", t, c, led_out, e_led);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_pending();
        int c;
        logic e_rdy;
        logic [6:0] e_led;
        do_reset();
        start_scan(16'h1111, 3'd7);
        for (int i = 0; i <= 200; i++) begin
            e_rdy = !((i >= 21 && i <= 63) || (i >= 128 && i <= 191));
            checks++; if (wr_ready !== e_rdy) begin
                errors++; $display("FAIL pend_wr_ready i=%0d got %b want %b", i, wr_ready, e_rdy);
            end
            if (i >= 1) begin
                c = i - 1;
                e_led = !lit(c, 7, 4'b0000) ? 7'b1111111 :
                        (c < 64) ? seg(4'd1) : (c < 192) ? seg(4'd2) : seg(4'd3);
                checks++; if (led_out !== e_led) begin
                    errors++; $display("FAIL pend_led c=%0d got %b want %b", c, led_out, e_led);
                end
            end
            if (i == 20 || i == 127) begin
                wr_valid = 1'b1;
                wr_data  = (i == 20) ? 16'h2222 : 16'h3333;
                $display("write 0x%h at scan cycle %0d", wr_data, i);
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drain();
        int c, restore;
        logic l, e_fd;
        logic [3:0] e_de;
        for (int r = 0; r < 2; r++) begin
            restore = (r == 1) ? 50 : -1;
            do_reset();
            start_scan(16'h4321, 3'd7);
            for (int i = 0; i <= 140; i++) begin
                e_fd = (i == 63) || (restore >= 0 && i % 64 == 63);
                checks++; if (frame_done !== e_fd) begin
                    errors++; $display("FAIL drain%0d_frame_done i=%0d got %b want %b", r, i, frame_done, e_fd);
                end
                if (i >= 1) begin
                    c = i - 1;
                    l = (c <= 63 || restore >= 0) && lit(c, 7, 4'b0000);
                    e_de = l ? (4'b0001 << ((c / 16) % 4)) : 4'b0000;
                    checks++; if (dig_en !== e_de) begin
                        errors++; $display("FAIL drain%0d_dig_en c=%0d got %b want %b", r, c, dig_en, e_de);
                    end
                end
                if (i == 40) en = 1'b0;
                if (i == restore) en = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_scan(16'h4321, 3'd7);
        for (int i = 0; i < 40; i++) begin
            wr_valid = (i == 30);
            if (i == 30) begin
                wr_data = 16'h5555;
                $display("write 0x%h at scan cycle %0d", wr_data, i);
            end
            if (i == 35) begin
                checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_pending_full got %b want 0", wr_ready); end
            end
            @(negedge clk);
        end
        checks++; if (dig_en !== 4'b0100) begin errors++; $display("FAIL rst_mid_digit2 got %b want 0100", dig_en); end
        wr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dig_en !== 4'b0000) begin errors++; $display("FAIL rst_mid_dig_en got %b want 0000", dig_en); end
        checks++; if (led_out !== 7'b1111111) begin errors++; $display("FAIL rst_mid_led got %b want 1111111", led_out); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_wr_ready got %b want 1", wr_ready); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_done got %b want 0", frame_done); end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++; if (frame_done !== 1'b0 || dig_en !== 4'b0000) begin
                errors++; $display("FAIL rst_mid_after i=%0d frame_done %b dig_en %b want 0/0000", i, frame_done, dig_en);
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; bright = 3'd0;
        test_reset();
        test_scan();
        test_pending();
        test_drain();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter SCAN_DIV, default 128: clk cycles per digit slot, multiple of 8, range 16..65536.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  display enable level.
REQ-006 Port wr_valid  input  1  frame-data write request.
REQ-007 Port wr_ready  output  1  controller can accept a write.
REQ-008 Port wr_data  input  4*NDIG  BCD nibbles; nibble i, bits [4i+3:4i], drives digit i; digit 0 is least significant.
REQ-009 Port bright  input  3  brightness level 0..7, sampled at each slot start.
REQ-010 Port led_out  output  7  active-low segments {a..g}, registered.
REQ-011 Port dig_en  output  NDIG  active-high digit enables, registered, one-hot or zero.
REQ-012 Port frame_done  output  1  one-cycle pulse at the end of each scanned frame.

Function
REQ-013 A write SHALL be accepted on a cycle with wr_valid=1 and wr_ready=1, loading wr_data into the pending register.
REQ-014 wr_ready SHALL be 1 exactly when the pending register is empty.
REQ-015 States SHALL be OFF, SCAN and DRAIN.
REQ-016 In OFF with en=1 and pending full, the controller SHALL move pending to active, clear pending, and enter SCAN at slot 0, digit 0 on the next cycle.
REQ-017 In SCAN, slot_cnt SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL wrap to 0 and the digit index SHALL advance 0..NDIG-1, wrapping to 0.
REQ-018 At the last cycle of digit NDIG-1 (frame end), frame_done SHALL pulse; if pending is full it SHALL be committed to active and cleared in that same cycle.
REQ-019 A write accepted on a frame-end cycle SHALL land in pending and SHALL NOT be committed until the next frame end.
REQ-020 If en=0 in SCAN, the controller SHALL enter DRAIN, finish the current frame, pulse frame_done, then enter OFF; en returning to 1 during DRAIN SHALL go back to SCAN with no scan discontinuity.
REQ-021 dig_en[d] SHALL be 1 only while the current digit is d and slot_cnt < (bright+1)*(SCAN_DIV/8); bright is latched at slot_cnt=0.
REQ-022 dig_en SHALL also be 0 for slot_cnt 0 and 1 of every slot (ghosting guard), and in OFF.
REQ-023 led_out SHALL decode the active nibble of the current digit: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, 10..15=1111111.
REQ-024 led_out and dig_en SHALL lag the counters by exactly one clk cycle; led_out SHALL be 1111111 whenever dig_en=0.

Reset
REQ-025 On reset=1 at a clk edge: state=OFF, slot_cnt=0, digit index=0, pending empty, active=all 0xF.
REQ-026 Reset values SHALL be led_out=1111111, dig_en=0, frame_done=0, wr_ready=1.
REQ-027 Reset mid-frame SHALL discard pending and active data with no further frame_done pulse.

Configuration
REQ-028 With SEG7_BLANK_LEADING_EN defined, zero digits above the most significant non-zero digit SHALL show 1111111 with dig_en=0; digit 0 SHALL never be blanked.
REQ-029 Without SEG7_BLANK_LEADING_EN, every digit SHALL be decoded per REQ-023.

Verification
REQ-030 NDIG=4, SCAN_DIV=16, bright=7: reset, write 0x4321, en=1 -> dig_en 0001 shows 1001111 on slot cycles 2..15, then digits 1..3 in order; frame_done every 64 cycles.
REQ-031 bright=0, SCAN_DIV=16 -> dig_en high for 0 cycles per slot; bright=3 -> cycles 2..7 only.
REQ-032 Write 0x1111, then write 0x2222 mid-frame -> wr_ready low until frame end; the display changes only on the frame after the frame_done pulse.
REQ-033 Drop en mid-frame -> remaining digits scanned, frame_done pulses once, dig_en=0 afterwards.
REQ-034 Write 0x00A5 -> digit 1 shows 1111111; with SEG7_BLANK_LEADING_EN, digits 3 and 2 show dig_en=0.
REQ-035 Assert reset during digit 2 -> next cycle dig_en=0, led_out=1111111, wr_ready=1.
